alu_arbiter: RTL

//  Shares the single-cycle ALU between NUM_REQ requesters (e.g. execute stage, address/branch helper).

---
 rtl/alu_arbiter_if.sv | 44 ++++
 rtl/alu_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side bus of the shared-ALU arbiter.
// slave: the arbiter; master: the requesters together with the ALU.
interface alu_arbiter_if #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_REQ       = 2,
  parameter int IDW           = $clog2(NUM_REQ)
) ();
  logic [NUM_REQ-1:0]               req_valid_i;
  logic [NUM_REQ-1:0]               req_ready_o;
  logic [NUM_REQ*REGISTER_SIZE-1:0] req_data1_i;
  logic [NUM_REQ*REGISTER_SIZE-1:0] req_data2_i;
  logic [NUM_REQ*7-1:0]             req_opcode_i;
  logic [NUM_REQ*3-1:0]             req_func3_i;
  logic [NUM_REQ*7-1:0]             req_func7_i;
  logic [NUM_REQ-1:0]               rsp_valid_o;
  logic [NUM_REQ-1:0]               rsp_ready_i;
  logic [REGISTER_SIZE-1:0]         rsp_result_o;
  logic                             rsp_error_o;
  logic [REGISTER_SIZE-1:0]         alu_data1_o;
  logic [REGISTER_SIZE-1:0]         alu_data2_o;
  logic [6:0]                       alu_opcode_o;
  logic [2:0]                       alu_func3_o;
  logic [6:0]                       alu_func7_o;
  logic [REGISTER_SIZE-1:0]         alu_result_i;
  logic                             alu_error_i;
  logic                             busy_o;
  logic [IDW-1:0]                   grant_id_o;

  modport slave (
    input  req_valid_i, req_data1_i, req_data2_i, req_opcode_i, req_func3_i, req_func7_i,
    input  rsp_ready_i, alu_result_i, alu_error_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_error_o,
    output alu_data1_o, alu_data2_o, alu_opcode_o, alu_func3_o, alu_func7_o,
    output busy_o, grant_id_o
  );

  modport master (
    output req_valid_i, req_data1_i, req_data2_i, req_opcode_i, req_func3_i, req_func7_i,
    output rsp_ready_i, alu_result_i, alu_error_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_error_o,
    input  alu_data1_o, alu_data2_o, alu_opcode_o, alu_func3_o, alu_func7_o,
    input  busy_o, grant_id_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between NUM_REQ requesters.
// One transaction in flight: IDLE (accept) -> EXEC (ALU computes) -> RESP (hold until taken).
module alu_arbiter #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_REQ       = 2,
  parameter int IDW           = $clog2(NUM_REQ)
) (
  input logic          clk_i,
  input logic          rst_ni,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [IDW-1:0]           last_grant_q;
  logic [IDW-1:0]           grant_q;
  logic [IDW-1:0]           win;
  logic [IDW-1:0]           cand;
  logic                     found;
  logic                     accept;
  logic                     done;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [REGISTER_SIZE-1:0] sel_data1, sel_data2;
  logic [6:0]               sel_opcode, sel_func7;
  logic [2:0]               sel_func3;
  logic [REGISTER_SIZE-1:0] alu_data1_q, alu_data2_q, rsp_result_q;
  logic [6:0]               alu_opcode_q, alu_func7_q;
  logic [2:0]               alu_func3_q;
  logic                     rsp_error_q;

  // Round-robin search: first valid requester after the last owner, wrapping.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((32'(last_grant_q) + i) % NUM_REQ);
      if (!found && bus.req_valid_i[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Operand mux for the winning requester (constant slices per requester).
  always_comb begin
    sel_data1  = '0;
    sel_data2  = '0;
    sel_opcode = '0;
    sel_func3  = '0;
    sel_func7  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win == IDW'(k)) begin
        sel_data1  = bus.req_data1_i[k*REGISTER_SIZE +: REGISTER_SIZE];
        sel_data2  = bus.req_data2_i[k*REGISTER_SIZE +: REGISTER_SIZE];
        sel_opcode = bus.req_opcode_i[k*7 +: 7];
        sel_func3  = bus.req_func3_i[k*3 +: 3];
        sel_func7  = bus.req_func7_i[k*7 +: 7];
      end
    end
  end

  // Next-state and handshake decode; ready is gated by reset so nothing is accepted while held.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found && rst_ni) begin
          req_ready[win] = 1'b1;
          accept         = 1'b1;
          state_d        = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (bus.rsp_ready_i[grant_q]) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Operand capture on accept, result capture in EXEC, owner rotation on response completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= IDW'(NUM_REQ - 1);
      grant_q      <= '0;
      alu_data1_q  <= '0;
      alu_data2_q  <= '0;
      alu_opcode_q <= '0;
      alu_func3_q  <= '0;
      alu_func7_q  <= '0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      if (accept) begin
        grant_q      <= win;
        alu_data1_q  <= sel_data1;
        alu_data2_q  <= sel_data2;
        alu_opcode_q <= sel_opcode;
        alu_func3_q  <= sel_func3;
        alu_func7_q  <= sel_func7;
      end
      if (state_q == EXEC) begin
        rsp_result_q <= bus.alu_result_i;
        rsp_error_q  <= bus.alu_error_i;
      end
      if (done) last_grant_q <= grant_q;
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.rsp_valid_o  = rsp_valid;
  assign bus.rsp_result_o = rsp_result_q;
  assign bus.rsp_error_o  = rsp_error_q;
  assign bus.alu_data1_o  = alu_data1_q;
  assign bus.alu_data2_o  = alu_data2_q;
  assign bus.alu_opcode_o = alu_opcode_q;
  assign bus.alu_func3_o  = alu_func3_q;
  assign bus.alu_func7_o  = alu_func7_q;
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.grant_id_o   = grant_q;

endmodule
